// File: rtl/game_timer_pkg.sv
// game_timer_pkg: session state encoding, divide-ratio helper and digit preload value.
// Define TIMER_FAST_SIM_EN to make div_ratio return the short simulation ratio.
package game_timer_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      LOAD   = ST_LOAD,
      RUN    = ST_RUN,
      PAUSED = ST_PAUSED,
      DONE   = ST_DONE
   } state_t;
   localparam logic [3:0] PRELOAD = 4'b1100;
`ifdef TIMER_FAST_SIM_EN
   localparam bit FAST_SIM = 1'b1;
`else
   localparam bit FAST_SIM = 1'b0;
`endif
   function automatic int div_ratio(input int clk_hz, input int tick_hz, input int fast_div);
      return FAST_SIM ? fast_div : clk_hz / tick_hz;
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: DIV-cycle counter with clear and hold; emits a registered one-cycle wrap pulse.
module tick_prescaler #(
   parameter int DIV   = 8,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic hold,
   input  logic tick_en,
   output logic wrap
);
   localparam logic [CNT_W-1:0] TOP = CNT_W'(DIV - 1);
   logic [CNT_W-1:0] cnt, cnt_nxt;
   // a tick already issued this cycle is consumed even when pausing, so resume never repeats it
   always_comb cnt_nxt = clr ? '0 : (en && (!hold || wrap)) ? ((cnt == TOP) ? '0 : cnt + 1'b1) : cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         wrap <= tick_en && (cnt_nxt == TOP);
      end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: seconds tick, digit preload pulse and game-session FSM for the countdown chain.
// Define TIMER_FAST_SIM_EN to divide by FAST_DIV instead of CLK_HZ/TICK_HZ.
module game_timer_ctrl
   import game_timer_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 1,
   parameter int CNT_W    = 26,
   parameter int FAST_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic pause,
   input  logic timeout_in,
   output logic reconfig,
   output logic tick,
   output logic top_no_borrow,
   output logic running,
   output logic game_over
);
   localparam int DIV = div_ratio(CLK_HZ, TICK_HZ, FAST_DIV);
   if (DIV < 2) begin : g_div_min
      $error("game_timer_ctrl: divide ratio must be at least 2");
   end
   if ((64'd1 << CNT_W) < 64'(DIV)) begin : g_cnt_w
      $error("game_timer_ctrl: CNT_W too narrow for divide ratio");
   end
   state_t state, nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:        nxt = start ? LOAD : IDLE;
         LOAD:        nxt = RUN;
         RUN, PAUSED: nxt = start ? LOAD : timeout_in ? DONE : pause ? PAUSED : RUN;
         DONE:        nxt = start ? LOAD : DONE;
         default:     nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         reconfig  <= 1'b0;
         running   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= nxt;
         reconfig  <= nxt == LOAD;
         running   <= nxt == RUN;
         game_over <= nxt == DONE;
      end
   assign top_no_borrow = 1'b1;
   tick_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_presc (
      .clk     (clk),
      .rst     (rst),
      .en      (state == RUN),
      .clr     (nxt != RUN && nxt != PAUSED),
      .hold    (nxt == PAUSED),
      .tick_en (nxt == RUN),
      .wrap    (tick)
   );
endmodule
